alu_seq: RTL and testbench

- Parametrised, registered successor to the 32-bit combinational datapath ALU.
- Handshaked op interface; adds shifts, an iterative unsigned multiply, a carry flag, illegal-op detection, and a true hold-on-NOP.
- Sits between the register-file read stage and writeback; the controller issues one op at a time and waits for `done`.

---
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/done handshake and iterative multiply.
// Ports: clk, reset (sync, active-high), start, op1, op2, alu_control_code
//        in; busy, done, result, v/c/n/z flags, illegal_op out.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [3:0]       alu_control_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             v_flag,
   output logic             c_flag,
   output logic             n_flag,
   output logic             z_flag,
   output logic             illegal_op
);

   localparam logic [3:0] C_AND  = 4'b0000;
   localparam logic [3:0] C_OR   = 4'b0001;
   localparam logic [3:0] C_ADD  = 4'b0010;
   localparam logic [3:0] C_MUL  = 4'b0011;
   localparam logic [3:0] C_SLL  = 4'b0100;
   localparam logic [3:0] C_SRL  = 4'b0101;
   localparam logic [3:0] C_SUB  = 4'b0110;
   localparam logic [3:0] C_SLT  = 4'b0111;
   localparam logic [3:0] C_SRA  = 4'b1000;
   localparam logic [3:0] C_NOR  = 4'b1001;
   localparam logic [3:0] C_NAND = 4'b1100;
   localparam logic [3:0] C_XOR  = 4'b1101;
   localparam logic [3:0] C_NOP  = 4'b1111;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   localparam logic [SHW:0]   CNT_INIT = (SHW+1)'(WIDTH);
   localparam logic [SHW:0]   CNT_LAST = (SHW+1)'(1);
   localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

   logic [0:0]         r_state;
   logic [SHW:0]       r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic               r_done;
   logic [WIDTH-1:0]   r_result;
   logic               r_v;
   logic               r_c;
   logic               r_n;
   logic               r_z;
   logic               r_illegal;

   logic [SHW-1:0]     w_shamt;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_sub;
   logic               w_add_v;
   logic               w_sub_v;
   logic [WIDTH:0]     w_sll;
   logic [WIDTH:0]     w_srl;
   logic [WIDTH:0]     w_sra;
   logic [WIDTH-1:0]   w_res;
   logic               w_v;
   logic               w_c;
   logic               w_legal;
   logic               w_write;
   logic [2*WIDTH-1:0] w_acc_next;

   assign w_shamt = op2[SHW-1:0];
   assign w_add   = {1'b0, op1} + {1'b0, op2};
   assign w_sub   = {1'b0, op1} + {1'b0, ~op2} + ONE_EXT;
   assign w_add_v = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                    (w_add[WIDTH-1] != op1[WIDTH-1]);
   assign w_sub_v = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                    (w_sub[WIDTH-1] != op1[WIDTH-1]);

   // One extra bit on the exit side of each shift catches the last bit
   // shifted out; with shamt=0 that bit is the zero padding.
   assign w_sll = {1'b0, op1} << w_shamt;
   assign w_srl = {op1, 1'b0} >> w_shamt;
   assign w_sra = $signed({op1, 1'b0}) >>> w_shamt;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_comb begin
      w_res   = '0;
      w_v     = 1'b0;
      w_c     = 1'b0;
      w_legal = 1'b1;
      w_write = 1'b1;
      case (alu_control_code)
         C_AND:  w_res = op1 & op2;
         C_OR:   w_res = op1 | op2;
         C_NOR:  w_res = ~(op1 | op2);
         C_NAND: w_res = ~(op1 & op2);
         C_XOR:  w_res = op1 ^ op2;
         C_ADD: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = w_add_v;
         end
         C_SUB: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];
            w_v   = w_sub_v;
         end
         C_SLT: begin
            w_res    = '0;
            w_res[0] = w_sub[WIDTH-1] ^ w_sub_v;
         end
         C_SLL: begin
            w_res = w_sll[WIDTH-1:0];
            w_c   = w_sll[WIDTH];
         end
         C_SRL: begin
            w_res = w_srl[WIDTH:1];
            w_c   = w_srl[0];
         end
         C_SRA: begin
            w_res = w_sra[WIDTH:1];
            w_c   = w_sra[0];
         end
         C_MUL: w_write = 1'b0;
         C_NOP: w_write = 1'b0;
         default: begin
            w_write = 1'b0;
            w_legal = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_v       <= 1'b0;
         r_c       <= 1'b0;
         r_n       <= 1'b0;
         r_z       <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (start) begin
               r_illegal <= ~w_legal;
               if (alu_control_code == C_MUL) begin
                  r_state  <= S_MUL;
                  r_cnt    <= CNT_INIT;
                  r_acc    <= '0;
                  r_mcand  <= {{WIDTH{1'b0}}, op1};
                  r_mplier <= op2;
               end else begin
                  r_done <= 1'b1;
                  if (w_write) begin
                     r_result <= w_res;
                     r_v      <= w_v;
                     r_c      <= w_c;
                     r_n      <= w_res[WIDTH-1];
                     r_z      <= (w_res == '0);
                  end
               end
            end
         end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
            // Final partial product lands on this edge.
            if (r_cnt == CNT_LAST) begin
               r_state  <= S_IDLE;
               r_done   <= 1'b1;
               r_result <= w_acc_next[WIDTH-1:0];
               r_v      <= 1'b0;
               r_c      <= |w_acc_next[2*WIDTH-1:WIDTH];
               r_n      <= w_acc_next[WIDTH-1];
               r_z      <= (w_acc_next[WIDTH-1:0] == '0);
            end
         end
      end
   end

   assign busy       = (r_state == S_MUL);
   assign done       = r_done;
   assign result     = r_result;
   assign v_flag     = r_v;
   assign c_flag     = r_c;
   assign n_flag     = r_n;
   assign z_flag     = r_z;
   assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32).
// Drives ops on the falling edge, checks outputs 1ns after the rising edge.
module tb_alu_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [3:0]  code;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        v_flag;
   logic        c_flag;
   logic        n_flag;
   logic        z_flag;
   logic        illegal_op;

   int n_pass = 0;
   int n_total = 0;

   alu_seq #(.WIDTH(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .op1              (op1),
      .op2              (op2),
      .alu_control_code (code),
      .busy             (busy),
      .done             (done),
      .result           (result),
      .v_flag           (v_flag),
      .c_flag           (c_flag),
      .n_flag           (n_flag),
      .z_flag           (z_flag),
      .illegal_op       (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // flags packed as {v,c,n,z}
   task automatic chk_out(input string tag, input logic [31:0] r,
                          input logic [3:0] f, input logic d);
      chk({tag, "_res"}, result, r);
      chk({tag, "_flags"}, {v_flag, c_flag, n_flag, z_flag}, f);
      chk({tag, "_done"}, done, d);
   endtask

   task automatic issue(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      code  = c;
      op1   = a;
      op2   = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   int  cyc;
   logic saw_done;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      code  = 4'b0;
      op1   = '0;
      op2   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_out("rst", 32'h0, 4'b0000, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ill", illegal_op, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
      chk_out("add_ovf", 32'h8000_0000, 4'b1010, 1'b1);
      idle();
      chk("add_ovf_done_drop", done, 1'b0);

      issue(4'b0010, 32'hFFFF_FFFF, 32'h1);
      chk_out("add_carry", 32'h0, 4'b0101, 1'b1);

      issue(4'b0110, 32'h5, 32'h5);
      chk_out("sub_eq", 32'h0, 4'b0101, 1'b1);

      issue(4'b0111, 32'h8000_0000, 32'h1);
      chk_out("slt_ovf", 32'h1, 4'b0000, 1'b1);

      issue(4'b0011, 32'h0001_0000, 32'h0001_0000);
      chk("mul1_busy0", busy, 1'b1);
      chk("mul1_done0", done, 1'b0);
      for (int i = 1; i <= 31; i++) begin
         @(negedge clk);
         start = (i == 3) || (i == 17) || (i == 31);
         code  = 4'b0010;
         op1   = 32'h1234;
         op2   = 32'h1;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      chk("mul1_busy31", busy, 1'b1);
      chk("mul1_done31", done, 1'b0);
      chk("mul1_hold31", result, 32'h1);
      idle();
      chk_out("mul1", 32'h0, 4'b0101, 1'b1);
      chk("mul1_busy_end", busy, 1'b0);

      issue(4'b0011, 32'h7, 32'h6);
      cyc = 0;
      while (!done && cyc < 40) begin
         idle();
         cyc++;
      end
      chk("mul2_latency", cyc, 32);
      chk_out("mul2", 32'd42, 4'b0000, 1'b1);

      issue(4'b0100, 32'h8000_0001, 32'h1);
      chk_out("sll", 32'h2, 4'b0100, 1'b1);
      issue(4'b0100, 32'h5, 32'h0);
      chk_out("sll_zero", 32'h5, 4'b0000, 1'b1);
      issue(4'b1000, 32'h8000_0000, 32'h4);
      chk_out("sra", 32'hF800_0000, 4'b0010, 1'b1);
      issue(4'b0101, 32'h8000_0000, 32'd31);
      chk_out("srl", 32'h1, 4'b0000, 1'b1);

      issue(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk_out("add_neg", 32'hFFFF_FFFE, 4'b0110, 1'b1);
      issue(4'b1111, 32'h1, 32'h1);
      chk_out("nop", 32'hFFFF_FFFE, 4'b0110, 1'b1);
      chk("nop_ill", illegal_op, 1'b0);
      issue(4'b1010, 32'h1, 32'h1);
      chk_out("illegal", 32'hFFFF_FFFE, 4'b0110, 1'b1);
      chk("illegal_flag", illegal_op, 1'b1);
      issue(4'b0000, 32'hF0F0_F0F0, 32'hFFFF_0000);
      chk_out("and", 32'hF0F0_0000, 4'b0010, 1'b1);
      chk("and_ill", illegal_op, 1'b0);

      issue(4'b0011, 32'h3, 32'h3);
      repeat (9) idle();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_out("abort", 32'h0, 4'b0000, 1'b0);
      chk("abort_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         idle();
         if (done || busy) saw_done = 1'b1;
      end
      chk("abort_quiet", saw_done, 1'b0);

      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      code  = 4'b0010;
      op1   = 32'h1;
      op2   = 32'h1;
      @(posedge clk);
      #1;
      chk_out("rst_start", 32'h0, 4'b0000, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      idle();
      chk_out("rst_start_after", 32'h0, 4'b0000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
